// File: rtl/arb_req_holder.sv
// arb_req_holder: converts one-cycle client request pulses into level requests
// for a downstream round-robin arbiter. Each client has a saturating pending
// counter. Its request stays high until grants have drained every accepted pulse.
// Optional starvation watchdog: define ARB_REQ_HOLDER_WATCHDOG_EN to compile it in.
// Without the macro, starve is tied low.
module arb_req_holder #(
  parameter int CLIENTS  = 32,
  parameter int PEND_W   = 2,
  parameter int MAX_WAIT = CLIENTS - 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [CLIENTS-1:0] req_pulse,
  input  logic [CLIENTS-1:0] grant,
  output logic [CLIENTS-1:0] request,
  output logic               busy,
  output logic [CLIENTS-1:0] overflow,
  output logic               spurious_grant,
  output logic [CLIENTS-1:0] starve
);

  localparam logic [PEND_W-1:0]  PEND_MAX = '1;
  localparam logic [CLIENTS-1:0] ONE_HOT0 = {{(CLIENTS-1){1'b0}}, 1'b1};

  // Reject illegal configurations at elaboration time.
  if (CLIENTS < 2 || CLIENTS > 64 || PEND_W < 1 || MAX_WAIT < 1) begin : g_bad_params
    $error("arb_req_holder: illegal parameter combination");
  end

  logic [PEND_W-1:0]  pend      [CLIENTS];
  logic [PEND_W-1:0]  pend_next [CLIENTS];
  logic [CLIENTS-1:0] valid_grant;
  logic [CLIENTS-1:0] full;
  logic [CLIENTS-1:0] accept;
  logic [CLIENTS-1:0] overflow_set;
  logic               multi_grant;
  logic               spurious_set;

  // Decode the level request from the registered counters only, so no input reaches an output combinationally.
  always_comb begin
    request = '0;
    full    = '0;
    for (int i = 0; i < CLIENTS; i++) begin
      request[i] = (pend[i] != '0);
      full[i]    = (pend[i] == PEND_MAX);
    end
  end

  assign busy        = |request;
  assign valid_grant = grant & request;

  // A full counter still accepts a pulse when a valid grant frees a slot in the same cycle.
  assign accept       = req_pulse & ~(full & ~valid_grant);
  assign overflow_set = req_pulse & full & ~valid_grant;

  // A grant is spurious if it hits an idle client or if more than one grant bit is high.
  assign multi_grant  = ((grant & (grant - ONE_HOT0)) != '0);
  assign spurious_set = (|(grant & ~request)) | multi_grant;

  // Next pending count. Accept and grant together cancel. Neither can wrap,
  // because accept excludes full and valid_grant excludes empty.
  always_comb begin
    for (int i = 0; i < CLIENTS; i++) begin
      pend_next[i] = pend[i];
      if (accept[i] && !valid_grant[i]) begin
        pend_next[i] = pend[i] + 1'b1;
      end else if (valid_grant[i] && !accept[i]) begin
        pend_next[i] = pend[i] - 1'b1;
      end
    end
  end

  // Counter and sticky flag registers. Reset discards pending work and ignores that cycle's inputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < CLIENTS; i++) begin
        pend[i] <= '0;
      end
      overflow       <= '0;
      spurious_grant <= 1'b0;
    end else begin
      for (int i = 0; i < CLIENTS; i++) begin
        pend[i] <= pend_next[i];
      end
      overflow       <= overflow | overflow_set;
      spurious_grant <= spurious_grant | spurious_set;
    end
  end

`ifdef ARB_REQ_HOLDER_WATCHDOG_EN
  localparam int                WAIT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  logic [WAIT_W-1:0]  wait_cnt  [CLIENTS];
  logic [WAIT_W-1:0]  wait_next [CLIENTS];
  logic [CLIENTS-1:0] waiting;
  logic [CLIENTS-1:0] starve_set;

  assign waiting = request & ~grant;

  // Count consecutive unserved cycles per client. A waiting cycle that brings the count to MAX_WAIT flags starvation.
  always_comb begin
    starve_set = '0;
    for (int i = 0; i < CLIENTS; i++) begin
      wait_next[i] = '0;
      if (waiting[i]) begin
        wait_next[i]  = (wait_cnt[i] == WAIT_MAX) ? WAIT_MAX : wait_cnt[i] + 1'b1;
        starve_set[i] = (wait_cnt[i] >= WAIT_LAST);
      end
    end
  end

  // Wait counters and sticky starvation flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < CLIENTS; i++) begin
        wait_cnt[i] <= '0;
      end
      starve <= '0;
    end else begin
      for (int i = 0; i < CLIENTS; i++) begin
        wait_cnt[i] <= wait_next[i];
      end
      starve <= starve | starve_set;
    end
  end
`else
  assign starve = '0;
`endif

endmodule

// File: doc/arb_req_holder.md
ARB_REQ_HOLDER -- requirements
Module: arb_req_holder

Interface
REQ-001 Parameter CLIENTS, default 32, number of requestor clients; legal range 2..64.
REQ-002 Parameter PEND_W, default 2, width of each per-client pending counter; max pending per client = 2^PEND_W-1.
REQ-003 Parameter MAX_WAIT, default CLIENTS-1, watchdog wait limit in cycles; used only when watchdog is compiled in.
REQ-004 clock  input  1  single clock; all state updates on posedge clock.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req_pulse  input  CLIENTS  one-cycle request events from clients; multiple pulses per client accumulate.
REQ-007 grant  input  CLIENTS  grant vector from the downstream round-robin arbiter; at most one bit high per cycle.
REQ-008 request  output  CLIENTS  level request to the downstream arbiter; request[i] = (pend[i] != 0).
REQ-009 busy  output  1  OR-reduction of request.
REQ-010 overflow  output  CLIENTS  sticky per-client flag, pulse dropped at full counter.
REQ-011 spurious_grant  output  1  sticky flag, grant seen for a client with request low or more than one grant bit high.
REQ-012 starve  output  CLIENTS  sticky per-client watchdog flag.

Function
REQ-013 Block SHALL hold a PEND_W-bit pending counter pend[i] per client; request is decoded from registered pend only (no input-to-output combinational path).
REQ-014 Per cycle, per client: inc = req_pulse[i] && !(full && !dec); dec = grant[i] && request[i]; pend[i] next = pend[i] + inc - dec.
REQ-015 req_pulse[i] and valid grant[i] in same cycle SHALL leave pend[i] unchanged, including at full (no overflow).
REQ-016 req_pulse[i] with pend[i] = max and no valid grant SHALL drop the pulse, keep pend[i] = max, set overflow[i] next cycle.
REQ-017 pend[i] SHALL never wrap: no increment past max, no decrement below 0.
REQ-018 grant[i] with request[i] low SHALL not change pend[i] and SHALL set spurious_grant next cycle.
REQ-019 More than one grant bit high in a cycle SHALL set spurious_grant; each valid grant bit still decrements its own counter.
REQ-020 request[i] SHALL stay high every cycle from the cycle after the first accepted pulse until the cycle after the grant that drains pend[i] to 0 (hold-until-grant contract of the arbiter).
REQ-021 Latency: req_pulse at cycle N (pend=0) -> request high at N+1; draining grant at cycle M -> request low at M+1.
REQ-022 Sticky flags SHALL clear only on reset.

Reset
REQ-023 On reset high at posedge: all pend = 0, request = 0, busy = 0, overflow = 0, spurious_grant = 0, starve = 0, watchdog counters = 0.
REQ-024 Reset mid-operation SHALL discard all pending requests; req_pulse and grant in a reset cycle SHALL be ignored.
REQ-025 First post-reset cycle SHALL accept req_pulse normally.

Configuration
REQ-026 Macro ARB_REQ_HOLDER_WATCHDOG_EN SHALL compile in the starvation watchdog.
REQ-027 With macro: per-client wait counter (width clog2(MAX_WAIT+1)) increments each cycle request[i] && !grant[i], saturates at MAX_WAIT, clears on grant[i] or request[i] low; reaching MAX_WAIT with request[i] still high and no grant SHALL set starve[i] next cycle.
REQ-028 Without macro: no wait counters instantiated, starve tied to 0; all other behaviour identical.

Verification
REQ-029 Single request: req_pulse[4] at cycle 1, grant[4] at cycle 5 -> request[4] high cycles 2..5, low at 6, pend[4] = 0.
REQ-030 Accumulate: three pulses on client 7 at cycles 1,2,3, grants at 6,8,10 -> request[7] high cycles 2..10, low at 11, overflow[7] = 0.
REQ-031 Overflow: four pulses on client 2 with no grant -> pend[2] = 3, overflow[2] = 1 one cycle after the 4th pulse; then pulse+grant same cycle -> pend stays 3, no further effect.
REQ-032 Spurious: grant[9] with request[9] low; separately grant = 0x0000_0003 -> spurious_grant = 1 next cycle, pend counters unaffected for invalid bits.
REQ-033 Reset mid-operation: pend[0] = 2, pend[31] = 1, reset asserted one cycle -> all request = 0 next cycle; pulse in first post-reset cycle raises request one cycle later.
REQ-034 Watchdog (macro defined, CLIENTS = 32): request[5] held with no grant for 31 cycles -> starve[5] = 1; grant at 31st waiting cycle -> starve[5] stays 0; macro undefined -> starve = 0 always.
